// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch sequencer for the 8-bit core.
// One req/ack memory transaction per instruction, valid/ready to the decoder, squashing on redirect.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] pc_out,
  input  logic [ADDR_W-1:0] pc_inc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                squash_q, squash_d;
  logic                fetch_done;

  // An ack completes a real fetch only if no redirect wins this cycle and the
  // transaction it answers was not already squashed by an earlier redirect.
  assign fetch_done = (state_q == ST_REQ) && mem_ack && !br_taken && !squash_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (fetch_done) begin
          state_d = ST_VALID;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_VALID: begin
        if (br_taken || instr_ready) begin
          if (en) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    squash_d      = squash_q;
    mem_req_d     = (state_d == ST_REQ);
    instr_valid_d = (state_d == ST_VALID);

    if (br_taken) begin
      pc_d = br_target;
    end else if (fetch_done) begin
      pc_d = pc_inc;
    end else begin
      pc_d = pc_q;
    end

    if (fetch_done) begin
      instr_d    = mem_rdata;
      instr_pc_d = pc_q;
    end else begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end

    // A redirect with no ack leaves the old request outstanding; its ack must be dropped.
    if (state_q == ST_REQ) begin
      if (br_taken) begin
        squash_d = !mem_ack;
      end else if (mem_ack) begin
        squash_d = 1'b0;
      end else begin
        squash_d = squash_q;
      end
    end else begin
      squash_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      instr_q       <= {DATA_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
      instr_valid_q <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      squash_q      <= squash_d;
    end
  end

  assign pc_out      = pc_q;
  assign mem_addr    = pc_q;
  assign mem_req     = mem_req_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared each cycle against a transaction-level reference model and a memory-image scoreboard.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, en, br_taken, mem_ack, instr_ready;
  logic [7:0] br_target, mem_rdata, pc_inc;
  logic [7:0] pc_out, mem_addr, instr, instr_pc;
  logic       mem_req, instr_valid;

  always #5 clk = ~clk;

  assign pc_inc = pc_out + 8'd1;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .pc_out      (pc_out),
    .pc_inc      (pc_inc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] m_pc, m_instr, m_ipc;
  logic       m_req, m_valid, m_sq;

  // Memory responder state
  logic [7:0] mem_img [256];
  bit         txn_active;
  logic [7:0] txn_addr;
  int         txn_wait;
  int         lat_cfg;
  bit         spurious;

  task automatic model_step();
    if (reset) begin
      m_pc = 8'h00; m_req = 1'b0; m_valid = 1'b0;
      m_instr = 8'h00; m_ipc = 8'h00; m_sq = 1'b0;
    end else if (m_req) begin
      if (br_taken) begin
        m_pc = br_target;
        m_sq = !mem_ack;
      end else if (mem_ack) begin
        if (m_sq) begin
          m_sq = 1'b0;
        end else begin
          m_instr = mem_rdata; m_ipc = m_pc; m_pc = m_pc + 8'd1;
          m_valid = 1'b1; m_req = 1'b0;
        end
      end
    end else if (m_valid) begin
      if (br_taken || instr_ready) begin
        m_valid = 1'b0;
        m_req   = en;
        if (br_taken) m_pc = br_target;
      end
    end else begin
      m_req = en;
      if (br_taken) m_pc = br_target;
    end
  endtask

  task automatic mem_drive();
    if (!txn_active && mem_req === 1'b1) begin
      txn_active = 1'b1;
      txn_addr   = mem_addr;
      txn_wait   = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    end
    if (txn_active) begin
      if (txn_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_img[txn_addr];
      end else begin
        txn_wait--;
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end else begin
      mem_ack   = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
      mem_rdata = 8'($urandom);
    end
  endtask

  task automatic check_outputs();
    check_val("pc_out", pc_out, m_pc);
    check_val("mem_addr", mem_addr, m_pc);
    check_val("mem_req", 8'(mem_req), 8'(m_req));
    check_val("instr_valid", 8'(instr_valid), 8'(m_valid));
    check_val("instr", instr, m_instr);
    check_val("instr_pc", instr_pc, m_ipc);
  endtask

  task automatic tick();
    if (instr_valid === 1'b1 && instr_ready && !br_taken && !reset)
      check_val("sb_instr", instr, mem_img[instr_pc]);
    @(posedge clk);
    model_step();
    if (reset || mem_ack) txn_active = 1'b0;
    @(negedge clk);
    check_outputs();
    mem_drive();
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && instr_valid !== 1'b1; i++) tick();
    check_val(tag, 8'(instr_valid), 8'h01);
  endtask

  task automatic wait_req(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && mem_req !== 1'b1; i++) tick();
    check_val(tag, 8'(mem_req), 8'h01);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; br_taken = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap_instr, snap_pc;
    reset = 1'b1; en = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    instr_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    m_pc = 8'h00; m_req = 1'b0; m_valid = 1'b0; m_instr = 8'h00; m_ipc = 8'h00; m_sq = 1'b0;
    txn_active = 1'b0; txn_addr = 8'h00; txn_wait = 0; lat_cfg = 1; spurious = 1'b0;
    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    mem_img[0] = 8'hA5;

    // Reset state
    tick(); tick(); tick();
    check_val("rst_mem_req", 8'(mem_req), 8'h00);
    check_val("rst_valid", 8'(instr_valid), 8'h00);
    check_val("rst_pc", pc_out, 8'h00);
    check_val("rst_instr", instr, 8'h00);

    // Basic fetch, ack two cycles after request
    reset = 1'b0; en = 1'b1; instr_ready = 1'b1;
    tick();
    check_val("s1_req", 8'(mem_req), 8'h01);
    check_val("s1_addr0", mem_addr, 8'h00);
    wait_valid("s1_valid", 10);
    check_val("s1_instr", instr, 8'hA5);
    check_val("s1_ipc", instr_pc, 8'h00);
    check_val("s1_pc", pc_out, 8'h01);
    wait_req("s1_req2", 10);
    check_val("s1_addr1", mem_addr, 8'h01);

    // Backpressure holds instruction and stops fetching
    instr_ready = 1'b0;
    wait_valid("s2_valid", 10);
    snap_instr = instr; snap_pc = pc_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("s2_hold_valid", 8'(instr_valid), 8'h01);
      check_val("s2_hold_instr", instr, snap_instr);
      check_val("s2_no_req", 8'(mem_req), 8'h00);
      check_val("s2_hold_pc", pc_out, snap_pc);
    end
    instr_ready = 1'b1;
    tick();

    // Branch during VALID squashes the held instruction
    do_reset();
    en = 1'b1; br_taken = 1'b1; br_target = 8'h04;
    tick();
    br_taken = 1'b0;
    wait_valid("s3_valid", 10);
    check_val("s3_ipc", instr_pc, 8'h04);
    check_val("s3_pc", pc_out, 8'h05);
    br_taken = 1'b1; br_target = 8'h40; instr_ready = 1'b1;
    tick();
    br_taken = 1'b0; instr_ready = 1'b0;
    check_val("s3_squash", 8'(instr_valid), 8'h00);
    wait_req("s3_req", 10);
    check_val("s3_addr", mem_addr, 8'h40);
    wait_valid("s3_valid2", 10);
    check_val("s3_ipc2", instr_pc, 8'h40);

    // Branch in REQ before ack discards the in-flight response
    do_reset();
    lat_cfg = 3; en = 1'b1; instr_ready = 1'b1;
    tick();
    tick();
    br_taken = 1'b1; br_target = 8'h20;
    tick();
    br_taken = 1'b0;
    check_val("s4_req", 8'(mem_req), 8'h01);
    check_val("s4_addr", mem_addr, 8'h20);
    instr_ready = 1'b0;
    wait_valid("s4_valid", 20);
    check_val("s4_ipc", instr_pc, 8'h20);
    check_val("s4_instr", instr, mem_img[8'h20]);

    // PC wrap from FF to 00
    do_reset();
    lat_cfg = 0; en = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
    tick();
    br_taken = 1'b0;
    wait_valid("s5_valid", 10);
    check_val("s5_ipc", instr_pc, 8'hFF);
    check_val("s5_pc", pc_out, 8'h00);
    instr_ready = 1'b1;
    wait_req("s5_req", 10);
    check_val("s5_addr", mem_addr, 8'h00);

    // Reset during an outstanding request; late acks ignored
    do_reset();
    lat_cfg = 5; en = 1'b1;
    tick();
    wait_req("s6_req", 5);
    tick();
    reset = 1'b1;
    tick();
    check_val("s6_req_clr", 8'(mem_req), 8'h00);
    check_val("s6_pc", pc_out, 8'h00);
    check_val("s6_valid", 8'(instr_valid), 8'h00);
    reset = 1'b0; en = 1'b0; spurious = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("s6_idle_req", 8'(mem_req), 8'h00);
      check_val("s6_idle_valid", 8'(instr_valid), 8'h00);
    end

    // Randomized traffic
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 149) == 0);
      en          = ($urandom_range(0, 7) != 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      br_target   = 8'($urandom);
      instr_ready = ($urandom_range(0, 4) < 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
